// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the fetch (I)
// and memory-stage (D) ports; also sequences the memory dump on halt.
module dmem_arbiter #(
  parameter int N   = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_req,
  input  logic [N-1:0] i_addr,
  output logic [N-1:0] i_rdata,
  output logic         i_done,
  output logic         i_stall,
  input  logic         d_req,
  input  logic         d_wr,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_done,
  output logic         d_stall,
  input  logic         halt,
  output logic         mem_en,
  output logic         mem_wr,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  output logic         mem_dump,
  output logic         busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DUMP   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]   state_q, state_d;
  logic         owner_q, owner_d;   // 1 = D port owns the access
  logic         last_q, last_d;     // 1 = D was granted last
  logic         wr_q, wr_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         i_done_q, i_done_d;
  logic         d_done_q, d_done_d;
  logic [N-1:0] i_rdata_q, i_rdata_d;
  logic [N-1:0] d_rdata_q, d_rdata_d;
  logic         i_elig, d_elig, grant_d;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    // A port pulsing done this cycle is masked so it cannot be re-granted at once.
    i_elig    = i_req & ~i_done_q;
    d_elig    = d_req & ~d_done_q;
    grant_d   = d_elig & (~i_elig | ~last_q);
    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_DUMP;
        end else if (i_elig || d_elig) begin
          owner_d = grant_d;
          last_d  = grant_d;
          addr_d  = grant_d ? d_addr : i_addr;
          wdata_d = grant_d ? d_wdata : '0;
          wr_d    = grant_d & d_wr;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) begin
            if (owner_q) d_rdata_d = mem_rdata;
            else         i_rdata_d = mem_rdata;
          end
          d_done_d = owner_q;
          i_done_d = ~owner_q;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DUMP:   state_d = S_HALTED;
      default:  state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    mem_en    = (state_q == S_ACCESS);
    mem_wr    = mem_en & wr_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    mem_dump  = (state_q == S_DUMP);
    busy      = (state_q != S_IDLE);
    i_done    = i_done_q;
    d_done    = d_done_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    i_stall   = (state_q == S_HALTED) ? i_req : (i_req & ~i_done_q);
    d_stall   = (state_q == S_HALTED) ? d_req : (d_req & ~d_done_q);
  end

endmodule
